sf_pkt_arbiter: RTL and testbench
=================================

SF_PKT_ARBITER -- requirements
Module: sf_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4 (legal 2..8): number of packet requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 32 (legal >=32): word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester word valid.
REQ-006 SHALL have port req_data_i  input  NUM_REQ*DATA_WIDTH  per-requester word; requester n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester word accepted this cycle.
REQ-008 SHALL have port fifo_full_i  input  1  full flag from downstream store-and-forward FIFO.
REQ-009 SHALL have port fifo_wren_o  output  1  FIFO write enable.
REQ-010 SHALL have port fifo_wdata_o  output  DATA_WIDTH  FIFO write data.
REQ-011 SHALL have port grant_o  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-012 SHALL have port pkt_done_o  output  1  one-cycle pulse, registered, the cycle after a packet's last word is written.
REQ-013 SHALL have port pkt_cnt_o  output  16  packets forwarded, saturating at 16'hFFFF.
REQ-014 SHALL have port err_cnt_o  output  16  packets whose last word has a nonzero [31:24] (CRC error), saturating at 16'hFFFF.

Function
REQ-015 SHALL treat a packet as: header word (length L = data[31:28], 0..15), then L body words, then one last word; total L+2 words.
REQ-016 SHALL implement FSM states ARB and XFER; reset state ARB.
REQ-017 In ARB, if any req_valid_i bit is set, SHALL select the first valid requester searching round-robin from (last_grant+1) mod NUM_REQ, load grant_o one-hot and enter XFER next cycle; no word is transferred in ARB.
REQ-018 In ARB with no valid request SHALL stay in ARB, grant_o = 0.
REQ-019 In XFER a word transfers iff req_valid_i[g] & !fifo_full_i, where g is the granted index.
REQ-020 fifo_wren_o SHALL equal the transfer condition; req_ready_o[g] SHALL equal it; all other req_ready_o bits SHALL be 0; both combinational from current inputs and state.
REQ-021 fifo_wdata_o SHALL equal req_data_i word of requester g while in XFER, 0 otherwise.
REQ-022 On the header transfer SHALL latch L and clear a 5-bit word counter; each subsequent transfer increments it.
REQ-023 The transfer with counter == L+1 (the last word) SHALL: return FSM to ARB, set last_grant = g, clear grant_o next cycle, pulse pkt_done_o next cycle, increment pkt_cnt_o, and increment err_cnt_o if that word's [31:24] != 0.
REQ-024 Grant SHALL be held for the whole packet regardless of other requests; no preemption.
REQ-025 Stalls (valid low or fifo_full_i high) SHALL freeze counter and state indefinitely; no timeout.
REQ-026 Minimum packet-to-packet gap SHALL be exactly one ARB cycle.
REQ-027 Counter width SHALL cover L+1 = 16 without overflow; L = 0 packet SHALL be two words.
REQ-028 Counters at 16'hFFFF SHALL hold; pkt_cnt_o and err_cnt_o increment in the same cycle when both apply.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: FSM = ARB, grant_o = 0, req_ready_o = 0, fifo_wren_o = 0, fifo_wdata_o = 0, pkt_done_o = 0, pkt_cnt_o = 0, err_cnt_o = 0, counter = 0, last_grant = NUM_REQ-1 (requester 0 highest priority first).
REQ-030 Reset mid-packet SHALL abandon the packet without further writes; recovery of the FIFO is the FIFO's own reset.

Verification
REQ-031 Single requester 0, header L=2, 2 body words, last word [31:24]=0, FIFO never full -> grant_o=0001 one cycle after valid, 4 consecutive fifo_wren_o, pkt_done_o pulse, pkt_cnt_o=1, err_cnt_o=0.
REQ-032 All 4 requesters continuously valid with L=0 packets -> grant order 0,1,2,3,0; each grant 2 write cycles + 1 ARB cycle.
REQ-033 fifo_full_i high 3 cycles mid-packet -> fifo_wren_o and req_ready_o low those 3 cycles, word count unchanged, packet completes with L+2 writes total.
REQ-034 Last word [31:24]=8'hA5 -> err_cnt_o increments by 1, pkt_cnt_o increments by 1.
REQ-035 rst_n low asynchronously during body word 1 of requester 2 -> outputs zero without a clock edge; after release requester 0 wins first when all valid.
REQ-036 Requester 1 raises valid while requester 0 mid-packet (L=15) -> grant stays 0001 for all 17 words, then 0010.

Source files
------------

// File: rtl/sf_pkt_arbiter.sv
// Round-robin packet arbiter feeding a store-and-forward FIFO.
// Grant is held for a whole header/body/last packet; counts packets and CRC errors.
module sf_pkt_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wren_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          pkt_done_o,
    output logic [15:0]                   pkt_cnt_o,
    output logic [15:0]                   err_cnt_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ARB, XFER} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0]      gidx_q, last_q, sel_idx;
    logic [NUM_REQ-1:0]    grant_q, sel_onehot;
    logic                  sel_found;
    logic [3:0]            len_q;
    logic [4:0]            cnt_q;
    logic                  hdr_q;
    logic                  pkt_done_q;
    logic [15:0]           pkt_cnt_q, err_cnt_q;
    logic                  xfer, last_word;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign words[n] = req_data_i[n*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting one past the previous owner.
    always_comb begin
        logic [IDX_W:0] idx;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        idx        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, last_q} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
            if (!sel_found && req_valid_i[idx[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx[IDX_W-1:0];
            end
        end
        sel_onehot[sel_idx] = 1'b1;
    end

    // cnt_q is cleared on the header and counts words after it, so the
    // packet word index is cnt_q+1 once the header is in; last is index L+1.
    always_comb begin
        cur_word     = words[gidx_q];
        xfer         = (state_q == XFER) && req_valid_i[gidx_q] && !fifo_full_i;
        last_word    = xfer && hdr_q && (cnt_q == {1'b0, len_q});
        fifo_wren_o  = xfer;
        req_ready_o  = xfer ? grant_q : '0;
        fifo_wdata_o = (state_q == XFER) ? cur_word : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (sel_found) state_d = XFER;
            XFER:    if (last_word) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= IDX_W'(NUM_REQ-1);
            len_q      <= '0;
            cnt_q      <= '0;
            hdr_q      <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            pkt_done_q <= last_word;
            if (state_q == ARB && sel_found) begin
                grant_q <= sel_onehot;
                gidx_q  <= sel_idx;
                hdr_q   <= 1'b0;
                cnt_q   <= '0;
            end
            if (xfer) begin
                if (!hdr_q) begin
                    hdr_q <= 1'b1;
                    len_q <= cur_word[31:28];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                end
            end
            if (last_word) begin
                grant_q <= '0;
                last_q  <= gidx_q;
                hdr_q   <= 1'b0;
                cnt_q   <= '0;
                if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
                if (cur_word[31:24] != 8'h00 && err_cnt_q != 16'hFFFF)
                    err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign grant_o    = grant_q;
    assign pkt_done_o = pkt_done_q;
    assign pkt_cnt_o  = pkt_cnt_q;
    assign err_cnt_o  = err_cnt_q;
endmodule

// File: tb/tb_sf_pkt_arbiter.sv
// Directed bench for sf_pkt_arbiter: per-requester word sources plus a write
// scoreboard holding the expected {grant, data} of every FIFO write in order.
module tb_sf_pkt_arbiter;
    logic         clk, rst_n;
    logic [3:0]   req_valid, req_ready, grant;
    logic [127:0] req_data;
    logic         fifo_full, fifo_wren, pkt_done;
    logic [31:0]  fifo_wdata;
    logic [15:0]  pkt_cnt, err_cnt;

    sf_pkt_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .fifo_full_i(fifo_full), .fifo_wren_o(fifo_wren), .fifo_wdata_o(fifo_wdata),
        .grant_o(grant), .pkt_done_o(pkt_done), .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, wr_cnt = 0, seq = 16;
    int wr_cyc[$];
    logic [35:0] exp_q[$];
    logic [31:0] mem [4][64];
    int head [4];
    int tail [4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic send(input int n, input int len, input logic [7:0] crc);
        logic [31:0] w;
        logic [3:0]  g;
        g = 4'b0001 << n;
        for (int i = 0; i < len + 2; i++) begin
            if (i == 0)            w = {4'(len), 4'h0, 8'(n), 16'(seq)};
            else if (i == len + 1) w = {crc, 8'(n), 16'(seq + i)};
            else                   w = {8'h3C, 8'(n), 16'(seq + i)};
            mem[n][tail[n]] = w;
            tail[n]++;
            exp_q.push_back({g, w});
        end
        seq += 32;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (pkt_done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s pkt_done_o timeout got=0 want=1", nm);
        end
    endtask

    // Source driver: pop a word when it was accepted, then present the next.
    initial begin
        logic [3:0] rdy;
        for (int n = 0; n < 4; n++) begin head[n] = 0; tail[n] = 0; end
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (rdy[n] && head[n] < tail[n]) head[n]++;
                req_valid[n] = head[n] < tail[n];
                req_data[n*32 +: 32] = req_valid[n] ? mem[n][head[n]] : 32'hDEAD_0000 | 32'(n);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && fifo_wren) begin
                wr_cnt++;
                wr_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected got grant=%b data=%h want no write", grant, fifo_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant, fifo_wdata} !== e || req_ready !== grant) begin
                        failures++;
                        $display("FAIL wr_%0d got grant=%b data=%h ready=%b want grant=%b data=%h ready=%b",
                                 wr_cnt, grant, fifo_wdata, req_ready, e[35:32], e[31:0], e[35:32]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b;
        bit found;
        rst_n = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_wren", fifo_wren, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Single requester 0, L=2, clean CRC
        send(0, 2, 8'h00);
        @(negedge clk);
        chk("t1_arb_grant", grant, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_grant", grant, 4'b0001);
            chk("t1_wren", fifo_wren, 1);
        end
        @(negedge clk);
        chk("t1_done", pkt_done, 1);
        chk("t1_wren_off", fifo_wren, 0);
        chk("t1_grant_off", grant, 0);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_err_cnt", err_cnt, 0);
        @(negedge clk);
        chk("t1_done_pulse", pkt_done, 0);

        // L=0 packet with CRC error byte A5
        send(0, 0, 8'hA5);
        wait_done("t2");
        chk("t2_pkt_cnt", pkt_cnt, 2);
        chk("t2_err_cnt", err_cnt, 1);

        // FIFO full for 3 cycles after the header
        base = wr_cnt;
        send(0, 3, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("t3_hdr_wren", fifo_wren, 1);
        @(posedge clk);
        #1 fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_wren", fifo_wren, 0);
            chk("t3_stall_ready", req_ready, 0);
            chk("t3_stall_grant", grant, 4'b0001);
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_done("t3");
        chk("t3_writes", wr_cnt - base, 5);
        chk("t3_pkt_cnt", pkt_cnt, 3);
        chk("t3_err_cnt", err_cnt, 1);

        // Async reset during body word 1 of requester 2
        send(2, 2, 8'h00);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (grant === 4'b0100 && fifo_wren === 1'b1) found = 1;
        end
        chk("t5_hdr_seen", found, 1);
        @(negedge clk);
        chk("t5_body1_wren", fifo_wren, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_wren", fifo_wren, 0);
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_wdata", fifo_wdata, 0);
        chk("t5_rst_pkt_cnt", pkt_cnt, 0);
        chk("t5_rst_err_cnt", err_cnt, 0);
        exp_q.delete();
        for (int n = 0; n < 4; n++) head[n] = tail[n];
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // All four valid with L=0 packets: grant 0,1,2,3,0
        @(negedge clk);
        b = wr_cyc.size();
        send(0, 0, 8'h00);
        send(1, 0, 8'h00);
        send(2, 0, 8'h00);
        send(3, 0, 8'h00);
        send(0, 0, 8'h00);
        for (int k = 0; k < 5; k++) wait_done("t4");
        chk("t4_writes", wr_cyc.size() - b, 10);
        if (wr_cyc.size() - b == 10) begin
            for (int k = 0; k < 5; k++) begin
                chk("t4_back_to_back", wr_cyc[b+2*k+1] - wr_cyc[b+2*k], 1);
                if (k < 4) chk("t4_arb_gap", wr_cyc[b+2*k+2] - wr_cyc[b+2*k+1], 2);
            end
        end
        chk("t4_pkt_cnt", pkt_cnt, 5);

        // No preemption: requester 1 arrives mid L=15 packet of requester 0
        base = wr_cnt;
        send(0, 15, 8'h00);
        repeat (5) @(negedge clk);
        send(1, 0, 8'h00);
        wait_done("t6_r0");
        chk("t6_r0_writes", wr_cnt - base, 17);
        wait_done("t6_r1");
        chk("t6_total_writes", wr_cnt - base, 19);
        chk("t6_pkt_cnt", pkt_cnt, 7);
        chk("t6_err_cnt", err_cnt, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
